fetch_stage: RTL and testbench

- Instruction fetch stage. Drives the instruction-memory request port from a local PC and accepts in-order responses.
- Presents {pc, inst} pairs to the decode stage (immediate_gen and register read) through a valid/ready handshake.
- Handles control-flow redirects from execute: updates the PC, flushes buffered instructions, and discards stale in-flight responses.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/fetch_stage.sv | 140 ++++++++++++++
 tb/tb_fetch_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;

  // Instruction word presented on the decode port while no entry is valid.
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Instructions are word aligned; the low two address bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a single-cycle flush,
// occupancy count and a combinational head for the decode port.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t        mem [DEPTH];
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;
  logic                do_push;
  logic                do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Push on a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count alone decides which slots hold data.
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues in-order fetches from a local PC under a
// credit limit, buffers responses for decode and handles execute redirects
// by flushing the buffer and discarding stale in-flight responses.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  // Architectural fetch state.
  logic [XLEN-1:0] pc,       pc_d;
  logic [XLEN-1:0] rsp_pc,   rsp_pc_d;
  logic [CW-1:0]   inflight, inflight_d;
  logic [CW-1:0]   drop_cnt, drop_cnt_d;

  // FIFO interface.
  fetch_entry_t    fifo_head;
  fetch_entry_t    fifo_push_data;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;

  logic [CW:0]     occupancy;
  logic            credit_ok;
  logic            req_fire;
  logic [XLEN-1:0] redirect_target;

  // Requests already issued still hold their credit until the response
  // returns, even when that response will be thrown away.
  assign occupancy = {1'b0, inflight} + {1'b0, fifo_count};
  assign credit_ok = occupancy < (CW+1)'(DEPTH);

  assign imem_req_valid  = !rst && !redirect_valid && credit_ok;
  assign imem_req_addr   = pc;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign redirect_target = align_pc(redirect_pc);

  // A response is kept only when no redirect is landing and nothing stale is pending.
  assign fifo_push      = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
  assign fifo_push_data = '{pc: rsp_pc, inst: imem_rsp_data};
  assign fifo_pop       = id_valid && id_ready;

  assign id_valid = !fifo_empty;
  assign id_pc    = fifo_head.pc;
  assign id_inst  = fifo_empty ? INST_NOP : fifo_head.inst;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state for PC, response PC, in-flight and drop counters.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    pc_d       = pc;
    rsp_pc_d   = rsp_pc;
    inflight_d = inflight;
    drop_cnt_d = drop_cnt;

    if (redirect_valid) begin
      // Everything in flight except a response landing right now is stale.
      pc_d       = redirect_target;
      rsp_pc_d   = redirect_target;
      drop_cnt_d = inflight - (imem_rsp_valid ? CW'(1) : CW'(0));
    end else begin
      if (req_fire)  pc_d     = pc + 32'd4;
      if (fifo_push) rsp_pc_d = rsp_pc + 32'd4;
      if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt_d = drop_cnt - CW'(1);
    end

    // No request fires during a redirect, so this is valid in both branches.
    case ({req_fire, imem_rsp_valid})
      2'b10:   inflight_d = inflight + CW'(1);
      2'b01:   inflight_d = inflight - CW'(1);
      default: inflight_d = inflight;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      pc       <= pc_d;
      rsp_pc   <= rsp_pc_d;
      inflight <= inflight_d;
      drop_cnt <= drop_cnt_d;
    end
  end

  // Memory must never answer a request that was not made.
  a_rsp_has_request : assert property (
    @(posedge clk) disable iff (rst) imem_rsp_valid |-> (inflight != '0)
  );

  // The credit limit keeps the FIFO from overflowing.
  a_no_overflow : assert property (
    @(posedge clk) disable iff (rst) !(fifo_push && fifo_full && !fifo_pop)
  );

  // A stalled decode port holds its instruction until accepted or flushed.
  a_stable_when_stalled : assert property (
    @(posedge clk) disable iff (rst)
      (id_valid && !id_ready && !redirect_valid)
        |=> (id_valid && $stable(id_inst) && $stable(id_pc))
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order latency-L memory model and
// a scoreboard of expected {pc, inst} pairs consumed at each decode handshake.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  fetch_stage #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: every address holds a distinct word.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a ^ 32'hA5A5_0000) + 32'h0000_0013;
  endfunction

  // In-order memory with fixed latency mem_lat (1..3), reset by the same rst.
  int          mem_lat;
  logic        pipe_v [1:3];
  logic [31:0] pipe_a [1:3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v[1] <= 1'b0;
      pipe_v[2] <= 1'b0;
      pipe_v[3] <= 1'b0;
    end else begin
      pipe_v[3] <= pipe_v[2];
      pipe_a[3] <= pipe_a[2];
      pipe_v[2] <= pipe_v[1];
      pipe_a[2] <= pipe_a[1];
      pipe_v[1] <= imem_req_valid && imem_req_ready;
      pipe_a[1] <= imem_req_addr;
    end
  end

  always_comb begin
    imem_rsp_valid = pipe_v[mem_lat];
    imem_rsp_data  = inst_of(pipe_a[mem_lat]);
  end

  // Scoreboard and bookkeeping.
  fetch_entry_t exp_q [$];
  logic [31:0]  req_exp;
  int           hs_cnt;
  int           n_checks;
  int           n_errors;
  bit           last_fire;
  bit           last_pipe1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Predict the sequential stream decode should see starting at base.
  task automatic push_stream(input logic [31:0] base);
    logic [31:0] a;
    a = base;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back('{pc: a, inst: inst_of(a)});
      a = a + 32'd4;
    end
  endtask

  // One clock: sample at the falling edge, then return 1 time unit after the rising edge.
  task automatic cycle();
    fetch_entry_t e;
    @(negedge clk);
    last_fire  = !rst && imem_req_valid && imem_req_ready;
    last_pipe1 = pipe_v[1];
    if (last_fire) begin
      check("req_addr", 64'(imem_req_addr), 64'(req_exp));
      req_exp = req_exp + 32'd4;
    end
    if (!rst && id_valid && id_ready) begin
      check("scoreboard_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("id_entry", {id_pc, id_inst}, {e.pc, e.inst});
      end
      hs_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int n, input string tag);
    int target;
    target = hs_cnt + n;
    for (int i = 0; i < 200 && hs_cnt < target; i++) cycle();
    check(tag, 64'(hs_cnt >= target), 64'd1);
  endtask

  // Run until the memory will deliver a response in the next cycle.
  task automatic wait_rsp_next(input bit need_fire, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      cycle();
      hit = last_pipe1 && (last_fire || !need_fire);
    end
    check(tag, 64'(hit), 64'd1);
  endtask

  task automatic redirect_start(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    #1;
    check("redirect_blocks_req", 64'(imem_req_valid), 64'd0);
    cycle();
  endtask

  task automatic redirect_end(input logic [31:0] target);
    logic [31:0] aligned;
    redirect_valid = 1'b0;
    aligned = target & ~32'h0000_0003;
    exp_q.delete();
    push_stream(aligned);
    req_exp = aligned;
    #1;
    check("flush_id_valid", 64'(id_valid), 64'd0);
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    hs_cnt         = 0;
    mem_lat        = 1;
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b1;
    req_exp        = RESET_PC;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_id_valid", 64'(id_valid), 64'd0);
    check("reset_req_valid", 64'(imem_req_valid), 64'd0);

    // Release: first request at RESET_PC, first instruction two cycles later (L=1).
    rst = 1'b0;
    push_stream(RESET_PC);
    req_exp = RESET_PC;
    #1;
    check("first_req", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, RESET_PC});
    cycle();
    check("latency_not_yet", 64'(id_valid), 64'd0);
    cycle();
    check("latency_first_valid", {31'd0, id_valid, id_pc}, {31'd0, 1'b1, RESET_PC});
    wait_hs(8, "stream_l1");

    // Decode stall: buffer fills, requests stop, head holds.
    id_ready = 1'b0;
    repeat (3) cycle();
    check("stall_head_early", {31'd0, id_valid, id_pc}, {31'd0, 1'b1, exp_q[0].pc});
    repeat (7) cycle();
    check("stall_head_late", {id_pc, id_inst}, {exp_q[0].pc, exp_q[0].inst});
    check("stall_no_req", 64'(imem_req_valid), 64'd0);
    id_ready = 1'b1;
    wait_hs(6, "stall_release");

    // Quiesce, then switch the memory to two-cycle latency.
    id_ready = 1'b0;
    repeat (6) cycle();
    mem_lat  = 2;
    id_ready = 1'b1;
    wait_hs(4, "stream_l2");

    // Redirect with two requests in flight: both old responses are dropped.
    wait_rsp_next(1'b1, "two_inflight_found");
    redirect_start(32'h0000_0100);
    redirect_end(32'h0000_0100);
    wait_hs(4, "redirect_100");

    // Redirect coinciding with a response, immediately followed by another.
    wait_rsp_next(1'b0, "rsp_next_found");
    redirect_start(32'h0000_0200);
    redirect_start(32'h0000_0300);
    redirect_end(32'h0000_0300);
    wait_hs(4, "redirect_300");

    // Misaligned redirect with the memory refusing requests for a while.
    imem_req_ready = 1'b0;
    redirect_start(32'h0000_0043);
    redirect_end(32'h0000_0043);
    repeat (3) cycle();
    for (int i = 0; i < 5; i++) begin
      check("req_held", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, 32'h0000_0040});
      cycle();
    end
    imem_req_ready = 1'b1;
    wait_hs(4, "resume_40");

    // Asynchronous reset with the FIFO full.
    id_ready = 1'b0;
    repeat (8) cycle();
    check("full_before_reset", 64'(id_valid), 64'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_id_valid", 64'(id_valid), 64'd0);
    check("async_rst_req_valid", 64'(imem_req_valid), 64'd0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_stream(RESET_PC);
    req_exp  = RESET_PC;
    id_ready = 1'b1;
    #1;
    check("post_reset_req", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, RESET_PC});
    wait_hs(4, "post_reset_stream");

    // PC wrap at the top of the address space.
    redirect_start(32'hFFFF_FFFC);
    redirect_end(32'hFFFF_FFFC);
    wait_hs(3, "pc_wrap");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
